l2_cache: RTL and testbench

L2_CACHE -- requirements
Module: l2_cache

---
 rtl/l2_cache_pkg.sv | 16 +
 rtl/l2_line_array.sv | 49 ++++
 rtl/l2_cache.sv | 138 +++++++++++++
 tb/tb_l2_cache.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/l2_cache_pkg.sv
// Shared geometry and FSM state type for the direct-mapped write-back L2 cache.
package l2_cache_pkg;

  localparam int unsigned LINE_W    = 128;
  localparam int unsigned INDEX_W   = 6;
  localparam int unsigned TAG_W     = 22;
  localparam int unsigned NUM_LINES = 64;
  localparam int unsigned ADDR_W    = TAG_W + INDEX_W;

  typedef enum logic [1:0] {
    COMPARE   = 2'd0,
    WRITEBACK = 2'd1,
    ALLOCATE  = 2'd2
  } state_t;

endpackage

// File: rtl/l2_line_array.sv
// Line storage: tag/data arrays without reset, valid/dirty bits with asynchronous reset.
// Combinational read of the addressed line, synchronous write.
module l2_line_array
  import l2_cache_pkg::*;
(
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic [INDEX_W-1:0] i_idx,
  output logic [TAG_W-1:0]   o_tag,
  output logic               o_valid,
  output logic               o_dirty,
  output logic [LINE_W-1:0]  o_data,
  input  logic               i_wr_en,
  input  logic [TAG_W-1:0]   i_wr_tag,
  input  logic [LINE_W-1:0]  i_wr_data,
  input  logic               i_wr_dirty,
  input  logic               i_clr_dirty
);

  logic [LINE_W-1:0]    r_data [NUM_LINES];
  logic [TAG_W-1:0]     r_tag  [NUM_LINES];
  logic [NUM_LINES-1:0] r_valid;
  logic [NUM_LINES-1:0] r_dirty;

  assign o_tag   = r_tag[i_idx];
  assign o_data  = r_data[i_idx];
  assign o_valid = r_valid[i_idx];
  assign o_dirty = r_dirty[i_idx];

  always_ff @(posedge i_clk) begin
    if (i_wr_en) begin
      r_data[i_idx] <= i_wr_data;
      r_tag[i_idx]  <= i_wr_tag;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_valid <= '0;
      r_dirty <= '0;
    end else if (i_wr_en) begin
      r_valid[i_idx] <= 1'b1;
      r_dirty[i_idx] <= i_wr_dirty;
    end else if (i_clr_dirty) begin
      r_dirty[i_idx] <= 1'b0;
    end
  end

endmodule

// File: rtl/l2_cache.sv
// Direct-mapped, write-back L2 cache between an L1 block interface and memory.
// Hits and clean write misses complete combinationally; other misses walk WRITEBACK/ALLOCATE.
module l2_cache
  import l2_cache_pkg::*;
(
  input  logic              clk,
  input  logic              proc_reset,
  input  logic              proc_read,
  input  logic              proc_write,
  input  logic [31:4]       proc_addr,
  input  logic [LINE_W-1:0] proc_wdata,
  output logic [LINE_W-1:0] proc_rdata,
  output logic              proc_ready,
  output logic              mem_read,
  output logic              mem_write,
  output logic [31:4]       mem_addr,
  output logic [LINE_W-1:0] mem_wdata,
  input  logic [LINE_W-1:0] mem_rdata,
  input  logic              mem_ready
);

  state_t            r_state;
  logic              r_mem_read;
  logic              r_mem_write;
  logic [31:4]       r_mem_addr;
  logic [LINE_W-1:0] r_mem_wdata;

  logic [INDEX_W-1:0] w_idx;
  logic [TAG_W-1:0]   w_tag_in;
  logic [TAG_W-1:0]   w_line_tag;
  logic               w_line_valid;
  logic               w_line_dirty;
  logic [LINE_W-1:0]  w_line_data;
  logic               w_req;
  logic               w_hit;
  logic               w_victim_dirty;
  logic               w_in_cmp;
  logic               w_install;
  logic               w_alloc_done;
  logic               w_wr_en;
  logic [LINE_W-1:0]  w_wr_data;
  logic               w_wr_dirty;
  logic               w_clr_dirty;

  assign w_idx          = proc_addr[9:4];
  assign w_tag_in       = proc_addr[31:10];
  assign w_req          = proc_read | proc_write;
  assign w_hit          = w_line_valid && (w_line_tag == w_tag_in);
  assign w_victim_dirty = w_line_valid && w_line_dirty;
  assign w_in_cmp       = (r_state == COMPARE);

  // Writes install directly on a hit or when the victim holds nothing worth saving.
  assign w_install    = w_in_cmp && proc_write && (w_hit || !w_victim_dirty);
  assign w_alloc_done = (r_state == ALLOCATE) && mem_ready;
  assign w_wr_en      = !proc_reset && (w_install || w_alloc_done);
  assign w_wr_data    = w_alloc_done ? mem_rdata : proc_wdata;
  assign w_wr_dirty   = !w_alloc_done;
  assign w_clr_dirty  = !proc_reset && (r_state == WRITEBACK) && mem_ready;

  assign proc_ready = !proc_reset && w_in_cmp &&
                      (w_install || (proc_read && !proc_write && w_hit));
  assign proc_rdata = (proc_ready && !proc_write) ? w_line_data : '0;

  assign mem_read  = r_mem_read;
  assign mem_write = r_mem_write;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;

  l2_line_array u_lines (
    .i_clk       (clk),
    .i_rst       (proc_reset),
    .i_idx       (w_idx),
    .o_tag       (w_line_tag),
    .o_valid     (w_line_valid),
    .o_dirty     (w_line_dirty),
    .o_data      (w_line_data),
    .i_wr_en     (w_wr_en),
    .i_wr_tag    (w_tag_in),
    .i_wr_data   (w_wr_data),
    .i_wr_dirty  (w_wr_dirty),
    .i_clr_dirty (w_clr_dirty)
  );

  // Memory strobes are loaded on the transition into each state so they are stable throughout.
  always_ff @(posedge clk or posedge proc_reset) begin
    if (proc_reset) begin
      r_state     <= COMPARE;
      r_mem_read  <= 1'b0;
      r_mem_write <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
    end else begin
      case (r_state)
        COMPARE: begin
          if (w_req && !w_hit) begin
            if (w_victim_dirty) begin
              r_state     <= WRITEBACK;
              r_mem_write <= 1'b1;
              r_mem_addr  <= {w_line_tag, w_idx};
              r_mem_wdata <= w_line_data;
            end else if (!proc_write) begin
              r_state    <= ALLOCATE;
              r_mem_read <= 1'b1;
              r_mem_addr <= proc_addr;
            end
          end
        end
        WRITEBACK: begin
          if (mem_ready) begin
            r_mem_write <= 1'b0;
            r_mem_wdata <= '0;
            if (proc_write) begin
              r_state    <= COMPARE;
              r_mem_addr <= '0;
            end else begin
              r_state    <= ALLOCATE;
              r_mem_read <= 1'b1;
              r_mem_addr <= proc_addr;
            end
          end
        end
        ALLOCATE: begin
          if (mem_ready) begin
            r_state    <= COMPARE;
            r_mem_read <= 1'b0;
            r_mem_addr <= '0;
          end
        end
        default: begin
          r_state     <= COMPARE;
          r_mem_read  <= 1'b0;
          r_mem_write <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_l2_cache.sv
// Scoreboard bench for l2_cache: the cache should behave as transparent memory with
// spec-defined miss latencies and memory traffic.
module tb_l2_cache;

  logic         clk = 1'b0;
  logic         proc_reset, proc_read, proc_write;
  logic [31:4]  proc_addr;
  logic [127:0] proc_wdata, proc_rdata;
  logic         proc_ready, mem_read, mem_write;
  logic [31:4]  mem_addr;
  logic [127:0] mem_wdata, mem_rdata;
  logic         mem_ready;

  l2_cache dut (
    .clk        (clk),
    .proc_reset (proc_reset),
    .proc_read  (proc_read),
    .proc_write (proc_write),
    .proc_addr  (proc_addr),
    .proc_wdata (proc_wdata),
    .proc_rdata (proc_rdata),
    .proc_ready (proc_ready),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .mem_ready  (mem_ready)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit           is_read;
    logic [127:0] rdata;
    int           lat;
    int           start;
    int           rd0;
    int           wr0;
    int           exp_rd;
    int           exp_wr;
  } exp_t;
  exp_t sbq[$];

  // Backing memory (bench side) and the processor-visible golden memory.
  logic [127:0] mem_store [logic [27:0]];
  logic [127:0] gold      [logic [27:0]];
  // Abstract per-index cache contents used only to predict hit/miss cost.
  bit           m_valid [64];
  bit           m_dirty [64];
  logic [21:0]  m_tag   [64];

  int           mem_lat = 3;
  logic [27:0]  cur_addr = '0;
  int           rd_cnt = 0, wr_cnt = 0;
  logic [27:0]  last_wb_addr = '0, last_rd_addr = '0;
  logic [127:0] last_wb_data = '0;

  function automatic logic [127:0] init_val(logic [27:0] a);
    logic [31:0] h;
    h = ({4'd0, a} * 32'h9E3779B1) ^ 32'h5A5A1357;
    return {h, ~h, h ^ 32'hFFFF0000, h + 32'd7};
  endfunction

  function automatic logic [127:0] mem_get(logic [27:0] a);
    if (mem_store.exists(a)) return mem_store[a];
    return init_val(a);
  endfunction

  function automatic logic [127:0] gold_get(logic [27:0] a);
    if (gold.exists(a)) return gold[a];
    return mem_get(a);
  endfunction

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h required %0h (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  // Memory responder: completes a request after mem_lat cycles with a one-cycle mem_ready.
  initial begin
    int cnt;
    logic [27:0] k;
    cnt = 0;
    mem_ready = 1'b0;
    mem_rdata = '0;
    forever begin
      @(negedge clk);
      mem_ready = 1'b0;
      mem_rdata = '0;
      if (proc_reset) begin
        cnt = 0;
      end else if (mem_read || mem_write) begin
        cnt++;
        if (cnt >= mem_lat) begin
          cnt = 0;
          mem_ready = 1'b1;
          k = mem_addr;
          if (mem_write) begin
            wr_cnt++;
            chk("wb_data", mem_wdata, gold_get(k));
            chk("wb_index", 128'(k[5:0]), 128'(cur_addr[5:0]));
            last_wb_addr = k;
            last_wb_data = mem_wdata;
            mem_store[k] = mem_wdata;
          end else begin
            rd_cnt++;
            chk("alloc_addr", 128'(k), 128'(cur_addr));
            last_rd_addr = k;
            mem_rdata = mem_get(k);
          end
        end
      end else begin
        cnt = 0;
      end
    end
  end

  // Monitor: invariants every cycle, scoreboard pop whenever the DUT completes a request.
  always @(negedge clk) begin
    exp_t e;
    chk("mem_rw_excl", 128'(mem_read & mem_write), 128'd0);
    if (!proc_ready) begin
      chk("rdata_idle", proc_rdata, 128'd0);
    end else if (sbq.size() == 0) begin
      total++;
      bad++;
      $display("FAIL spurious_ready: got proc_ready=1 required 0 (cycle %0d)", cyc);
    end else begin
      e = sbq.pop_front();
      if (e.is_read) chk("rdata", proc_rdata, e.rdata);
      chk("latency", 128'(cyc - e.start), 128'(e.lat));
      chk("mem_reads", 128'(rd_cnt - e.rd0), 128'(e.exp_rd));
      chk("mem_writes", 128'(wr_cnt - e.wr0), 128'(e.exp_wr));
    end
  end

  task automatic issue(input bit rd, input bit wr, input logic [27:0] a,
                       input logic [127:0] wd, input int lat);
    exp_t e;
    int idx;
    bit hit, vd, seen;
    idx = int'(a[5:0]);
    hit = m_valid[idx] && (m_tag[idx] == a[27:6]);
    vd  = m_valid[idx] && m_dirty[idx];
    e.is_read = !wr;
    e.rdata   = gold_get(a);
    e.exp_rd  = 0;
    e.exp_wr  = 0;
    if (hit) begin
      e.lat = 0;
    end else if (wr) begin
      e.lat    = vd ? lat + 1 : 0;
      e.exp_wr = vd ? 1 : 0;
    end else begin
      e.lat    = (vd ? lat : 0) + lat + 1;
      e.exp_wr = vd ? 1 : 0;
      e.exp_rd = 1;
    end
    if (wr) begin
      gold[a]      = wd;
      m_valid[idx] = 1'b1;
      m_tag[idx]   = a[27:6];
      m_dirty[idx] = 1'b1;
    end else if (!hit) begin
      m_valid[idx] = 1'b1;
      m_tag[idx]   = a[27:6];
      m_dirty[idx] = 1'b0;
    end
    mem_lat  = lat;
    cur_addr = a;
    @(posedge clk);
    #1;
    e.start = cyc;
    e.rd0   = rd_cnt;
    e.wr0   = wr_cnt;
    sbq.push_back(e);
    proc_read  = rd;
    proc_write = wr;
    proc_addr  = a;
    proc_wdata = wd;
    seen = 1'b0;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (proc_ready) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) begin
      total++;
      bad++;
      $display("FAIL ready_timeout: got no proc_ready required one for addr %0h", a);
      sbq.delete();
    end
    @(posedge clk);
    #1;
    proc_read  = 1'b0;
    proc_write = 1'b0;
  endtask

  initial begin
    logic [127:0] wd;
    logic [27:0]  a;
    int           r;
    proc_reset = 1'b0;
    proc_read  = 1'b0;
    proc_write = 1'b0;
    proc_addr  = '0;
    proc_wdata = '0;
    #2 proc_reset = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_ready", 128'(proc_ready), 128'd0);
    chk("rst_mem_read", 128'(mem_read), 128'd0);
    chk("rst_mem_write", 128'(mem_write), 128'd0);
    chk("rst_mem_addr", 128'(mem_addr), 128'd0);
    chk("rst_mem_wdata", mem_wdata, 128'd0);
    @(posedge clk);
    #1 proc_reset = 1'b0;

    // Clean read miss, then a repeat hit.
    mem_store[28'h1] = {16{8'hA5}};
    issue(1'b1, 1'b0, 28'h1, '0, 3);
    issue(1'b1, 1'b0, 28'h1, '0, 3);
    // Write hit, then conflicting read forces writeback of the dirty line.
    issue(1'b0, 1'b1, 28'h1, 128'h1234, 3);
    issue(1'b1, 1'b0, 28'h41, '0, 3);
    chk("wb_addr_dirty", 128'(last_wb_addr), 128'h1);
    chk("wb_data_dirty", last_wb_data, 128'h1234);
    chk("alloc_addr_new", 128'(last_rd_addr), 128'h41);
    // Clean write miss installs without memory traffic.
    wd = 128'hDEAD_BEEF_0000_1111_2222_3333_4444_5555;
    issue(1'b0, 1'b1, 28'h2, wd, 3);
    issue(1'b1, 1'b0, 28'h2, '0, 3);

    // Reset in the middle of ALLOCATE.
    mem_lat  = 6;
    cur_addr = 28'h3;
    @(posedge clk);
    #1;
    proc_read = 1'b1;
    proc_addr = 28'h3;
    repeat (3) @(negedge clk);
    chk("alloc_started", 128'(mem_read), 128'd1);
    @(posedge clk);
    #2 proc_reset = 1'b1;
    #1;
    chk("rst_abort_read", 128'(mem_read), 128'd0);
    chk("rst_abort_write", 128'(mem_write), 128'd0);
    proc_read = 1'b0;
    @(negedge clk);
    @(posedge clk);
    #1 proc_reset = 1'b0;
    for (int i = 0; i < 64; i++) m_valid[i] = 1'b0;
    gold.delete();
    issue(1'b1, 1'b0, 28'h3, '0, 2);

    // Read and write together on a hit: write wins.
    wd = 128'h0F0F_F0F0_1357_9BDF_2468_ACE0_AAAA_5555;
    issue(1'b1, 1'b1, 28'h3, wd, 2);
    issue(1'b1, 1'b0, 28'h3, '0, 2);

    // Random traffic over a few indices and tags to mix hits, conflicts and dirty victims.
    for (int i = 0; i < 300; i++) begin
      a  = {22'($urandom_range(0, 3)), 6'($urandom_range(0, 3))};
      wd = {$urandom, $urandom, $urandom, $urandom};
      r  = int'($urandom_range(0, 9));
      issue(r < 5 || r == 9, r >= 5, a, wd, int'($urandom_range(1, 4)));
    end

    repeat (4) @(negedge clk);
    chk("sb_drained", 128'(sbq.size()), 128'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
